// File: rtl/vram_writer_pkg.sv
// Shared widths, queue depth, write FSM encoding and queue entry layout for the VRAM writer.
package vram_writer_pkg;

  localparam int VRAM_ADDR_W = 13;
  localparam int VRAM_DATA_W = 8;
  localparam int WQ_DEPTH    = 4;
  localparam int WQ_ENTRY_W  = VRAM_ADDR_W + VRAM_DATA_W;
  localparam int WQ_CNT_W    = 3;
  localparam int WQ_PTR_W    = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } wr_state_e;

  typedef struct packed {
    logic [VRAM_ADDR_W-1:0] addr;
    logic [VRAM_DATA_W-1:0] data;
  } wq_entry_t;

  // The write pointer walks the whole 8K space and wraps from 8191 to 0.
  function automatic logic [VRAM_ADDR_W-1:0] nextPtr(input logic [VRAM_ADDR_W-1:0] ptr);
    return ptr + VRAM_ADDR_W'(1);
  endfunction

endpackage

// File: rtl/vram_writer_if.sv
// Host command channel: valid/ready handshake carrying either a pointer load or a data byte.
interface vram_writer_if;
  import vram_writer_pkg::*;

  logic                   hostValid;
  logic                   hostReady;
  logic                   hostSetAddr;
  logic [VRAM_ADDR_W-1:0] hostAddr;
  logic [VRAM_DATA_W-1:0] hostData;

  modport master (
    output hostValid, hostSetAddr, hostAddr, hostData,
    input  hostReady
  );

  modport slave (
    input  hostValid, hostSetAddr, hostAddr, hostData,
    output hostReady
  );

endinterface

// File: rtl/vram_writer_fifo.sv
// Four-entry first-in first-out queue of pending VRAM writes {address, data}.
module vram_write_fifo
  import vram_writer_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                push_i,
  input  logic                pop_i,
  input  wq_entry_t           data_i,
  output wq_entry_t           data_o,
  output logic                full_o,
  output logic                empty_o,
  output logic [WQ_CNT_W-1:0] count_o
);

  wq_entry_t             mem_q [WQ_DEPTH];
  logic [WQ_PTR_W-1:0]   wrPtr_q;
  logic [WQ_PTR_W-1:0]   rdPtr_q;
  logic [WQ_CNT_W-1:0]   count_q;
  logic                  doPush;
  logic                  doPop;

  // A push into a full queue is only legal when the head leaves on the same edge.
  assign doPush  = push_i && (!full_o || pop_i);
  assign doPop   = pop_i && !empty_o;
  assign full_o  = (count_q == WQ_CNT_W'(WQ_DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rdPtr_q];

  // Entry storage carries no reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (doPush) begin
      mem_q[wrPtr_q] <= data_i;
    end
  end

  // Pointer and occupancy bookkeeping; a simultaneous push and pop keeps the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) begin
        wrPtr_q <= wrPtr_q + WQ_PTR_W'(1);
      end
      if (doPop) begin
        rdPtr_q <= rdPtr_q + WQ_PTR_W'(1);
      end
      case ({doPush, doPop})
        2'b10:   count_q <= count_q + WQ_CNT_W'(1);
        2'b01:   count_q <= count_q - WQ_CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/vram_writer.sv
// Host-to-VRAM write path: pointer management, write queue and a 4-cycle setup/strobe/hold write FSM.
module vram_writer
  import vram_writer_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  vram_writer_if.slave           host,
  input  logic                   writeWindow_i,
  output logic [VRAM_ADDR_W-1:0] writeAddr_o,
  output logic [VRAM_DATA_W-1:0] writeData_o,
  output logic                   writeEn_o,
  output logic [WQ_CNT_W-1:0]    pending_o
);

  wr_state_e              state_q;
  wr_state_e              state_d;
  logic [VRAM_ADDR_W-1:0] ptr_q;
  logic [VRAM_ADDR_W-1:0] ptr_d;
  logic [VRAM_ADDR_W-1:0] addr_q;
  logic [VRAM_DATA_W-1:0] data_q;
  logic                   accept;
  logic                   pushEn;
  logic                   popEn;
  logic                   loadOut;
  logic                   fifoFull;
  logic                   fifoEmpty;
  wq_entry_t              fifoIn;
  wq_entry_t              fifoHead;

  // Address loads are refused while full too, so they never overtake queued data.
  assign host.hostReady = !rst && !fifoFull;
  assign accept         = host.hostValid && host.hostReady;
  assign pushEn         = accept && !host.hostSetAddr;
  assign fifoIn         = '{addr: ptr_q, data: host.hostData};

  vram_write_fifo u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (pushEn),
    .pop_i   (popEn),
    .data_i  (fifoIn),
    .data_o  (fifoHead),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty),
    .count_o (pending_o)
  );

  // Write pointer: loaded by address commands, advanced by each queued data byte.
  always_comb begin
    ptr_d = ptr_q;
    if (accept && host.hostSetAddr) begin
      ptr_d = host.hostAddr;
    end else if (pushEn) begin
      ptr_d = nextPtr(ptr_q);
    end
  end

  // State, pointer and output address/data registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      if (loadOut) begin
        addr_q <= fifoHead.addr;
        data_q <= fifoHead.data;
      end
    end
  end

  // Next state: a closed window during SETUP aborts without consuming the entry.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (!fifoEmpty && writeWindow_i) state_d = ST_SETUP;
      ST_SETUP:  state_d = writeWindow_i ? ST_STROBE : ST_IDLE;
      ST_STROBE: state_d = ST_HOLD;
      ST_HOLD:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Outputs: strobe only in STROBE, pop on the SETUP->STROBE edge, latch head on SETUP entry.
  always_comb begin
    writeEn_o = (state_q == ST_STROBE);
    popEn     = (state_q == ST_SETUP) && writeWindow_i;
    loadOut   = (state_q == ST_IDLE) && (state_d == ST_SETUP);
  end

  assign writeAddr_o = addr_q;
  assign writeData_o = data_q;

endmodule

// File: tb/tb_vram_writer.sv
// Randomised and directed bench for vram_writer with a queue-based scoreboard.
module tb_vram_writer;
  import vram_writer_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        writeWindow = 1'b0;
  logic [12:0] writeAddr;
  logic [7:0]  writeData;
  logic        writeEn;
  logic [2:0]  pending;

  vram_writer_if hostIf ();

  vram_writer dut (
    .clk           (clk),
    .rst           (rst),
    .host          (hostIf.slave),
    .writeWindow_i (writeWindow),
    .writeAddr_o   (writeAddr),
    .writeData_o   (writeData),
    .writeEn_o     (writeEn),
    .pending_o     (pending)
  );

  always #5 clk = ~clk;

  // Reference model: pointer as a plain integer, expected writes as a queue.
  int          modelPtr = 0;
  logic [20:0] expQ [$];
  int          acceptedCnt = 0;
  int          strobeCnt = 0;
  int          checks = 0;
  int          errors = 0;
  int          cycleCnt = 0;
  int          lastStrobeCycle = -1;
  int          lastGap = 0;
  bit          holdArmed = 0;
  logic [12:0] heldAddr;
  logic [7:0]  heldData;
  logic        prevWindow = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One host cycle: drive at posedge+1, decide handshake before the edge, update model at the edge.
  task automatic applyStimulus(input bit v, input bit sa, input logic [12:0] a,
                               input logic [7:0] d, input bit w, output bit acc);
    hostIf.hostValid   = v;
    hostIf.hostSetAddr = sa;
    hostIf.hostAddr    = a;
    hostIf.hostData    = d;
    writeWindow        = w;
    @(negedge clk);
    acc = v && hostIf.hostReady;
    @(posedge clk);
    if (acc) begin
      if (sa) begin
        modelPtr = int'(a);
      end else begin
        expQ.push_back({13'(modelPtr), d});
        modelPtr = (modelPtr + 1) % 8192;
        acceptedCnt++;
      end
    end
    #1;
  endtask

  task automatic idle(input int n, input bit w);
    bit acc;
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 13'h0, 8'h0, w, acc);
  endtask

  task automatic applyReset();
    rst = 1'b1;
    hostIf.hostValid = 1'b0;
    @(posedge clk);
    expQ.delete();
    modelPtr = 0;
    acceptedCnt = 0;
    strobeCnt = 0;
    #1;
    @(negedge clk);
    checkOutput("rstHostReady", hostIf.hostReady, 0);
    checkOutput("rstWriteEn", writeEn, 0);
    checkOutput("rstPending", pending, 0);
    checkOutput("rstWriteAddr", writeAddr, 0);
    checkOutput("rstWriteData", writeData, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("readyAfterReset", hostIf.hostReady, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic waitDrain(input int budget);
    for (int i = 0; i < budget && expQ.size() != 0; i++) idle(1, 1);
    idle(4, 1);
    checkOutput("drainEmpty", expQ.size(), 0);
  endtask

  // Monitor: compares every strobe against the scoreboard and tracks occupancy/handshake.
  always @(negedge clk) begin
    logic [20:0] e;
    cycleCnt++;
    if (rst) begin
      holdArmed = 0;
      lastStrobeCycle = -1;
    end else begin
      if (holdArmed) begin
        checkOutput("holdWriteEn", writeEn, 0);
        checkOutput("holdAddr", writeAddr, heldAddr);
        checkOutput("holdData", writeData, heldData);
        holdArmed = 0;
      end
      if (writeEn) begin
        strobeCnt++;
        checkOutput("windowBeforeStrobe", prevWindow, 1);
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpectedWrite: got addr 0x%0h data 0x%0h expected no write", writeAddr, writeData);
        end else begin
          e = expQ.pop_front();
          checkOutput("writeAddr", writeAddr, e[20:8]);
          checkOutput("writeData", writeData, e[7:0]);
        end
        if (lastStrobeCycle >= 0) begin
          lastGap = cycleCnt - lastStrobeCycle;
          checkOutput("strobeSpacing", lastGap >= 4, 1);
        end
        lastStrobeCycle = cycleCnt;
        holdArmed = 1;
        heldAddr = writeAddr;
        heldData = writeData;
      end
      checkOutput("pending", pending, acceptedCnt - strobeCnt);
      checkOutput("hostReady", hostIf.hostReady, (acceptedCnt - strobeCnt) != 4);
    end
    prevWindow = writeWindow;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit acc;
    int cnt;
    int savedStrobes;
    bit seen;
    hostIf.hostValid = 1'b0;
    hostIf.hostSetAddr = 1'b0;
    hostIf.hostAddr = '0;
    hostIf.hostData = '0;
    applyReset();

    // Pointer load then two bytes, four cycles between strobes.
    applyStimulus(1, 1, 13'h0100, 8'h00, 1, acc);
    applyStimulus(1, 0, 13'h0000, 8'h41, 1, acc);
    applyStimulus(1, 0, 13'h0000, 8'h07, 1, acc);
    idle(12, 1);
    checkOutput("req032Gap", lastGap, 4);
    checkOutput("req032Empty", expQ.size(), 0);

    // Pointer wraps from 0x1FFF to 0x0000.
    applyStimulus(1, 1, 13'h1FFF, 8'h00, 1, acc);
    applyStimulus(1, 0, 13'h0000, 8'hC3, 1, acc);
    applyStimulus(1, 0, 13'h0000, 8'h3C, 1, acc);
    waitDrain(40);

    // Closed window fills the queue; the fifth command waits for the first write.
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 0, 13'h0000, 8'(8'h10 + i), 0, acc);
      if (acc) cnt++;
    end
    checkOutput("req034Accepted", cnt, 4);
    checkOutput("req034Pending", pending, 4);
    checkOutput("req034Ready", hostIf.hostReady, 0);
    acc = 0;
    for (int i = 0; i < 40 && !acc; i++) applyStimulus(1, 0, 13'h0000, 8'h15, 1, acc);
    checkOutput("req034FifthAccepted", acc, 1);
    waitDrain(60);

    // Window drops while in SETUP: abort, entry kept, written after reopening.
    savedStrobes = strobeCnt;
    applyStimulus(1, 0, 13'h0000, 8'hA5, 1, acc);
    applyStimulus(0, 0, 13'h0000, 8'h00, 1, acc);
    idle(6, 0);
    checkOutput("req035Pending", pending, 1);
    checkOutput("req035NoStrobe", strobeCnt, savedStrobes);
    waitDrain(40);

    // Reset during STROBE discards the queue and clears the pointer.
    applyStimulus(1, 0, 13'h0000, 8'h77, 1, acc);
    applyStimulus(1, 0, 13'h0000, 8'h78, 1, acc);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (writeEn) seen = 1;
      else idle(1, 1);
    end
    checkOutput("req037SawStrobe", seen, 1);
    applyReset();
    applyStimulus(1, 0, 13'h0000, 8'h3C, 1, acc);
    waitDrain(40);

    // Randomised traffic with a flickering window.
    for (int i = 0; i < 800; i++) begin
      applyStimulus($urandom_range(0, 1) == 1, $urandom_range(0, 6) == 0,
                    13'($urandom), 8'($urandom), $urandom_range(0, 4) != 0, acc);
    end
    waitDrain(100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vram_writer.md
VRAM_WRITER -- requirements
Module: vram_writer

Interface
REQ-001 clk  in  1  system clock; all logic on its rising edge.
REQ-002 rst  in  1  synchronous, active-high reset.
REQ-003 hostValid  in  1  host presents a command this cycle.
REQ-004 hostReady  out  1  block accepts a command; a transfer occurs when hostValid & hostReady at a clk edge.
REQ-005 hostSetAddr  in  1  1 = load the write pointer from hostAddr; 0 = data write of hostData.
REQ-006 hostAddr  in  13  new write pointer value; used only when hostSetAddr=1.
REQ-007 hostData  in  8  character/attribute byte; used only when hostSetAddr=0.
REQ-008 writeWindow  in  1  1 = the VRAM is not being read by the readout logic; upstream deasserts it at least 2 cycles before readout starts.
REQ-009 writeAddr  out  13  VRAM write address.
REQ-010 writeData  out  8  VRAM write data.
REQ-011 writeEn  out  1  VRAM write strobe, active high.
REQ-012 pending  out  3  number of queued writes (0..4).

Function
REQ-013 An accepted command with hostSetAddr=1 shall load the write pointer with hostAddr on that edge and shall not enqueue anything.
REQ-014 An accepted command with hostSetAddr=0 shall enqueue {pointer, hostData} and increment the pointer by 1 mod 8192 (8191 wraps to 0).
REQ-015 A data command accepted in the cycle immediately after an address load shall use the newly loaded address.
REQ-016 The queue shall be a 4-entry FIFO, first in first out.
REQ-017 hostReady shall equal !full, where full means pending==4; an address command is refused while full, so ordering is preserved.
REQ-018 A push and a pop in the same cycle shall leave pending unchanged, including when pending is 4 or when pending is 1.
REQ-019 The write FSM shall have the states IDLE, SETUP, STROBE and HOLD.
REQ-020 IDLE->SETUP when the FIFO is not empty and writeWindow=1; SETUP drives writeAddr/writeData from the FIFO head with writeEn=0.
REQ-021 SETUP->STROBE if writeWindow is still 1, and the FIFO head is popped on that edge; if writeWindow=0, SETUP->IDLE with no pop and no write (abort).
REQ-022 STROBE asserts writeEn=1 for exactly one cycle, with addr/data held from SETUP; STROBE->HOLD unconditionally.
REQ-023 HOLD keeps addr/data stable with writeEn=0; HOLD->IDLE unconditionally.
REQ-024 writeAddr/writeData shall be registered and shall change only on entry to SETUP.
REQ-025 The minimum write cost is 4 cycles; sustained throughput is 1 write per 4 cycles while the window stays open.
REQ-026 Commands are accepted in every FSM state, independent of writeWindow.

Reset
REQ-027 While rst=1: state=IDLE, FIFO empty, pending=0, pointer=0, writeEn=0, writeAddr=0, writeData=0, hostReady=0.
REQ-028 hostReady shall be 1 in the first cycle after rst is released.
REQ-029 A reset asserted during STROBE shall force writeEn=0 on the next edge; the queued data is discarded.

Structure
REQ-030 A shared Verilog include shall define VRAM_ADDR_W=13, VRAM_DATA_W=8, WQ_DEPTH=4 and the FSM state encodings.
REQ-031 The FIFO shall be a sub-module, vram_write_fifo (21-bit entries, push/pop/full/empty/count).

Verification
REQ-032 Address 0x0100, then data 0x41 and 0x07 with writeWindow=1 -> strobes at 0x0100=0x41, then 0x0101=0x07, 4 cycles apart.
REQ-033 Address 0x1FFF, then two data bytes -> writes to 0x1FFF and then 0x0000.
REQ-034 writeWindow=0 while 5 data commands are offered -> 4 accepted, hostReady=0, pending=4; raise writeWindow -> 4 in-order writes, then the 5th is accepted.
REQ-035 writeWindow drops during SETUP -> no writeEn, pending unchanged, the same entry is written after the window reopens.
REQ-036 pending=4 and push coincides with pop in STROBE entry -> pending stays 4, hostReady=0, no entry lost.
REQ-037 rst pulsed during STROBE -> writeEn=0 next cycle, pending=0, pointer=0, hostReady=1 after release.
